// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters (IF and MEM stage), the
// arbiter and the single-ported unified memory.
//   i_*   : instruction fetch request / grant / response
//   d_*   : data access request / grant / error / response
//   mem_* : memory issue port (addr, write data, write enable) and read data
// Modports:
//   slave  : arbiter view (requests and mem_rdata in; grants, responses, issue out)
//   master : environment view (requesters plus memory), the mirror of slave
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_err;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_err, d_rvalid, d_rdata,
               mem_addr, mem_wd, mem_we
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_err, d_rvalid, d_rdata,
               mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Data wins by default; IF is forced through once data has won STARVE_LIMIT
// consecutive cycles while IF was waiting. Read responses (one cycle after
// issue) are tagged back to the requester that issued them.
// Ports:
//   clk    : clock, all state on posedge
//   reset  : synchronous, active-high; blocks grants and responses while high
//   bus    : mem_port_arbiter_if.slave (requests, grants, responses, memory port)
module mem_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_port_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_INSTR = 2'd1,
        RESP_DATA  = 2'd2
    } resp_e;

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    resp_e            resp_src_q, resp_src_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic force_i;
    logic data_win;
    logic if_win;
    logic d_aligned;

    always_comb begin
        force_i   = (STARVE_LIMIT != 0) && (starve_cnt_q >= LIMIT);
        d_aligned = (bus.d_addr[1:0] == 2'b00);

        // Data keeps priority unless IF is both waiting and starved.
        data_win  = !reset && bus.d_req && (!force_i || !bus.i_req);
        if_win    = !reset && bus.i_req && !data_win;

        bus.i_gnt    = if_win;
        bus.d_gnt    = data_win;
        bus.d_err    = data_win && !d_aligned;
        bus.mem_we   = data_win && d_aligned && bus.d_we;
        bus.mem_addr = data_win ? bus.d_addr : bus.i_addr;
        bus.mem_wd   = bus.d_wdata;

        // Gated by reset so an in-flight response vanishes in the reset cycle itself.
        bus.i_rvalid = !reset && (resp_src_q == RESP_INSTR);
        bus.d_rvalid = !reset && (resp_src_q == RESP_DATA);
        bus.i_rdata  = bus.mem_rdata;
        bus.d_rdata  = bus.mem_rdata;
    end

    always_comb begin
        resp_src_d = RESP_NONE;
        if (if_win) begin
            resp_src_d = RESP_INSTR;
        end else if (data_win && d_aligned && !bus.d_we) begin
            resp_src_d = RESP_DATA;
        end

        starve_cnt_d = starve_cnt_q;
        if (if_win || !bus.i_req) begin
            starve_cnt_d = '0;
        end else if (data_win && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_src_q   <= RESP_NONE;
            starve_cnt_q <= '0;
        end else begin
            resp_src_q   <= resp_src_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    logic mem_init;
    int   checks;
    int   errors;

    logic [31:0] mem [64];

    mem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_port_arbiter #(
        .DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(3), .CNT_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word-indexed, write at posedge, registered read.
    // Initial content of word i is 0xA000_0000 | i.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        end else begin
            if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;
            bus.mem_rdata <= mem[bus.mem_addr[7:2]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
    endtask

    task automatic test_reset();
        mem_init    = 1'b1;
        reset       = 1'b1;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h8;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h10;
        bus.d_wdata = 32'h1111_1111;
        #1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (bus.i_gnt !== 1'b0 || bus.d_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt cyc%0d: i_gnt=%b d_gnt=%b mem_we=%b expected 0 0 0",
                         c, bus.i_gnt, bus.d_gnt, bus.mem_we);
            end
            checks++;
            if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_rvalid cyc%0d: i_rvalid=%b d_rvalid=%b expected 0 0",
                         c, bus.i_rvalid, bus.d_rvalid);
            end
        end
        mem_init = 1'b0;
        reset    = 1'b0;
        idle_inputs();
        tick();
        checks++;
        if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: i_rvalid=%b d_rvalid=%b d_gnt=%b expected 0 0 0",
                     bus.i_rvalid, bus.d_rvalid, bus.d_gnt);
        end
    endtask

    task automatic test_if_read();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h8;
        #1;
        checks++;
        if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0 || bus.mem_addr !== 32'h8) begin
            errors++;
            $display("FAIL if_read_issue: i_gnt=%b d_gnt=%b mem_addr=%h expected 1 0 00000008",
                     bus.i_gnt, bus.d_gnt, bus.mem_addr);
        end
        tick();
        bus.i_req = 1'b0;
        #1;
        checks++;
        if (bus.i_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0 || bus.i_rdata !== 32'hA000_0002) begin
            errors++;
            $display("FAIL if_read_resp: i_rvalid=%b d_rvalid=%b i_rdata=%h expected 1 0 a0000002",
                     bus.i_rvalid, bus.d_rvalid, bus.i_rdata);
        end
        tick();
        checks++;
        if (bus.i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL if_read_single: i_rvalid=%b expected 0", bus.i_rvalid);
        end
    endtask

    task automatic test_write_then_read();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h10;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h0;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.i_gnt !== 1'b0 ||
            bus.mem_addr !== 32'h10 || bus.mem_wd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_issue: d_gnt=%b mem_we=%b i_gnt=%b addr=%h wd=%h expected 1 1 0 00000010 deadbeef",
                     bus.d_gnt, bus.mem_we, bus.i_gnt, bus.mem_addr, bus.mem_wd);
        end
        tick();
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        #1;
        checks++;
        if (bus.i_gnt !== 1'b1 || bus.mem_addr !== 32'h0 || bus.d_rvalid !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL write_then_if: i_gnt=%b addr=%h d_rvalid=%b mem_we=%b expected 1 00000000 0 0",
                     bus.i_gnt, bus.mem_addr, bus.d_rvalid, bus.mem_we);
        end
        tick();
        bus.i_req  = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h10;
        #1;
        checks++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hA000_0000) begin
            errors++;
            $display("FAIL write_if_resp: i_rvalid=%b i_rdata=%h expected 1 a0000000",
                     bus.i_rvalid, bus.i_rdata);
        end
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL read_issue: d_gnt=%b mem_we=%b expected 1 0", bus.d_gnt, bus.mem_we);
        end
        tick();
        bus.d_req = 1'b0;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.i_rvalid !== 1'b0 || bus.d_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_back: d_rvalid=%b i_rvalid=%b d_rdata=%h expected 1 0 deadbeef",
                     bus.d_rvalid, bus.i_rvalid, bus.d_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        // Write then read of the same word in consecutive cycles.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h14;
        bus.d_wdata = 32'h1234_5678;
        tick();
        bus.d_we = 1'b0;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_read_issue: d_gnt=%b mem_we=%b d_rvalid=%b expected 1 0 0",
                     bus.d_gnt, bus.mem_we, bus.d_rvalid);
        end
        tick();
        bus.d_addr = 32'h10;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL b2b_raw: d_rvalid=%b d_rdata=%h expected 1 12345678",
                     bus.d_rvalid, bus.d_rdata);
        end
        tick();
        bus.d_req = 1'b0;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL b2b_second_read: d_rvalid=%b d_rdata=%h expected 1 deadbeef",
                     bus.d_rvalid, bus.d_rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic exp_i;
        logic prev_i;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h4;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h20;
        prev_i     = 1'b0;
        #1;
        // Limit 3: data wins cycles 1-3, IF forced on 4, then data 5-7, IF on 8.
        for (int k = 1; k <= 8; k++) begin
            exp_i = (k == 4) || (k == 8);
            checks++;
            if (bus.i_gnt !== exp_i || bus.d_gnt !== !exp_i) begin
                errors++;
                $display("FAIL starve_gnt cyc%0d: i_gnt=%b d_gnt=%b expected %b %b",
                         k, bus.i_gnt, bus.d_gnt, exp_i, !exp_i);
            end
            if (k > 1) begin
                checks++;
                if (bus.i_rvalid !== prev_i || bus.d_rvalid !== !prev_i ||
                    bus.i_rdata !== (prev_i ? 32'hA000_0001 : 32'hA000_0008)) begin
                    errors++;
                    $display("FAIL starve_resp cyc%0d: i_rvalid=%b d_rvalid=%b rdata=%h expected %b %b %h",
                             k, bus.i_rvalid, bus.d_rvalid, bus.i_rdata, prev_i, !prev_i,
                             prev_i ? 32'hA000_0001 : 32'hA000_0008);
                end
            end
            prev_i = exp_i;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_misaligned();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h6;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'hC;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.d_err !== 1'b1 || bus.mem_we !== 1'b0 || bus.i_gnt !== 1'b0) begin
            errors++;
            $display("FAIL misalign_read: d_gnt=%b d_err=%b mem_we=%b i_gnt=%b expected 1 1 0 0",
                     bus.d_gnt, bus.d_err, bus.mem_we, bus.i_gnt);
        end
        tick();
        bus.d_req = 1'b0;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b0 || bus.i_gnt !== 1'b1 || bus.d_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_next: d_rvalid=%b i_gnt=%b d_err=%b expected 0 1 0",
                     bus.d_rvalid, bus.i_gnt, bus.d_err);
        end
        tick();
        bus.i_req   = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h12;
        bus.d_wdata = 32'h0;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.d_err !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL misalign_write: d_gnt=%b d_err=%b mem_we=%b expected 1 1 0",
                     bus.d_gnt, bus.d_err, bus.mem_we);
        end
        tick();
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h10;
        tick();
        bus.d_req = 1'b0;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL misalign_no_write: d_rvalid=%b d_rdata=%h expected 1 deadbeef",
                     bus.d_rvalid, bus.d_rdata);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h8;
        #1;
        checks++;
        if (bus.i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midreset_issue: i_gnt=%b expected 1", bus.i_gnt);
        end
        tick();
        reset       = 1'b1;
        bus.i_req   = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h10;
        bus.d_wdata = 32'h0BAD_F00D;
        #1;
        checks++;
        if (bus.i_rvalid !== 1'b0 || bus.mem_we !== 1'b0 || bus.d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL midreset_n1: i_rvalid=%b mem_we=%b d_gnt=%b expected 0 0 0",
                     bus.i_rvalid, bus.mem_we, bus.d_gnt);
        end
        tick();
        reset     = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        #1;
        checks++;
        if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_n2: i_rvalid=%b d_rvalid=%b expected 0 0",
                     bus.i_rvalid, bus.d_rvalid);
        end
        bus.d_req = 1'b1;
        tick();
        bus.d_req = 1'b0;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL midreset_write_dropped: d_rvalid=%b d_rdata=%h expected 1 deadbeef",
                     bus.d_rvalid, bus.d_rdata);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.mem_rdata = 32'h0;
        idle_inputs();
        test_reset();
        test_if_read();
        test_write_then_read();
        test_back_to_back();
        test_starvation();
        test_misaligned();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
